// File: rtl/shot_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shot_renderer                                                   |
// | Purpose  : Pixel stage behind vga_sync. Runs a once-per-frame projectile   |
// |            model of a basketball shot and paints ball, rim, backboard,     |
// |            floor and sky as a registered 12-bit RGB stream.                |
// | Ports    : clk, reset (async, active-low)                                  |
// |            p_tick, video_on, pixel_x[9:0], pixel_y[9:0]  - from vga_sync   |
// |            shoot, vx_in[3:0], vy_in[5:0]                 - shot control    |
// |            rgb[11:0]  - pixel colour, registered on p_tick                 |
// |            busy       - high whenever the FSM is not idle                  |
// |            scored     - one-clock pulse on entry to the scored state       |
// | Config   : `define BALL_ROUND_EN draws the ball as a disc instead of a      |
// |            square; physics always uses the square box.                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module shot_renderer #(
  parameter int X0          = 40,
  parameter int Y0          = 400,
  parameter int BALL_SIZE   = 8,
  parameter int HOOP_X      = 560,
  parameter int HOOP_Y      = 200,
  parameter int HOOP_W      = 32,
  parameter int FLOOR_Y     = 470,
  parameter int HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        shoot,
  input  logic [3:0]  vx_in,
  input  logic [5:0]  vy_in,
  output logic [11:0] rgb,
  output logic        busy,
  output logic        scored
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLIGHT = 2'd1,
    ST_SCORED = 2'd2,
    ST_MISS   = 2'd3
  } state_t;

  localparam int HOLD_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

  // All geometry is compared in 13-bit signed space so that a ball above
  // the top of the screen (negative y) compares correctly.
  localparam logic signed [12:0] c_ball     = 13'(BALL_SIZE);
  localparam logic signed [12:0] c_hoop_x   = 13'(HOOP_X);
  localparam logic signed [12:0] c_hoop_y   = 13'(HOOP_Y);
  localparam logic signed [12:0] c_hoop_r   = 13'(HOOP_X + HOOP_W);
  localparam logic signed [12:0] c_rim_bot  = 13'(HOOP_Y + 1);
  localparam logic signed [12:0] c_bb_top   = 13'(HOOP_Y - 40);
  localparam logic signed [12:0] c_bb_right = 13'(HOOP_X + HOOP_W + 3);
  localparam logic signed [12:0] c_floor    = 13'(FLOOR_Y);
  localparam logic signed [12:0] c_x_lim    = 13'(640 - BALL_SIZE);
  localparam logic        [9:0]  c_x0       = 10'(X0);
  localparam logic signed [10:0] c_y0       = 11'(Y0);
  localparam logic signed [7:0]  c_vy_min   = 8'shC0;  // -64
  localparam logic [HOLD_W-1:0]  c_hold_last = HOLD_W'(HOLD_FRAMES - 1);

  // ---------------------------------------------------------------- state
  state_t             state, state_n;
  logic               shoot_r, shoot_d;
  logic [9:0]         ball_x, ball_x_n;
  logic signed [10:0] ball_y, ball_y_n;
  logic [3:0]         vx, vx_n;
  logic signed [7:0]  vy, vy_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
  logic               scored_n;
  logic [11:0]        pix_color;

  // ---------------------------------------------------------------- physics
  logic               w_frame_tick;
  logic               w_launch;
  logic [9:0]         w_x_step;
  logic signed [10:0] w_y_step;
  logic signed [7:0]  w_vy_step;
  logic signed [12:0] w_x_new13, w_y_old13, w_y_new13;
  logic               w_hit, w_out;

  assign w_frame_tick = p_tick && (pixel_y == 10'd480) && (pixel_x == 10'd0);
  assign w_launch     = shoot_r && !shoot_d;

  assign w_x_step  = ball_x + {6'd0, vx};
  assign w_y_step  = ball_y - {{3{vy[7]}}, vy};
  assign w_vy_step = (vy == c_vy_min) ? vy : vy - 8'sd1;

  assign w_x_new13 = $signed({3'b000, w_x_step});
  assign w_y_old13 = {{2{ball_y[10]}}, ball_y};
  assign w_y_new13 = {{2{w_y_step[10]}}, w_y_step};

  // Score: falling, and the ball's bottom edge crossed the rim row this frame
  // while the whole box sits between the rim ends.
  assign w_hit = vy[7]
              && (w_y_old13 + c_ball <= c_hoop_y)
              && (c_hoop_y < w_y_new13 + c_ball)
              && (w_x_new13 >= c_hoop_x)
              && (w_x_new13 + c_ball <= c_hoop_r);

  assign w_out = (w_y_new13 + c_ball >= c_floor) || (w_x_new13 >= c_x_lim);

  assign busy = (state != ST_IDLE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      shoot_r  <= 1'b0;
      shoot_d  <= 1'b0;
      ball_x   <= c_x0;
      ball_y   <= c_y0;
      vx       <= 4'd0;
      vy       <= 8'sd0;
      hold_cnt <= '0;
      scored   <= 1'b0;
      rgb      <= 12'h000;
    end else begin
      state    <= state_n;
      shoot_r  <= shoot;
      shoot_d  <= shoot_r;
      ball_x   <= ball_x_n;
      ball_y   <= ball_y_n;
      vx       <= vx_n;
      vy       <= vy_n;
      hold_cnt <= hold_cnt_n;
      scored   <= scored_n;
      if (p_tick) begin
        rgb <= pix_color;
      end
    end
  end

  always_comb begin
    state_n    = state;
    ball_x_n   = ball_x;
    ball_y_n   = ball_y;
    vx_n       = vx;
    vy_n       = vy;
    hold_cnt_n = hold_cnt;
    scored_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        ball_x_n = c_x0;
        ball_y_n = c_y0;
        if (w_launch) begin
          vx_n    = vx_in;
          vy_n    = {2'b00, vy_in};
          state_n = ST_FLIGHT;
        end
      end
      ST_FLIGHT: begin
        if (w_frame_tick) begin
          ball_x_n = w_x_step;
          ball_y_n = w_y_step;
          vy_n     = w_vy_step;
          if (w_hit) begin
            state_n  = ST_SCORED;
            scored_n = 1'b1;
          end else if (w_out) begin
            state_n = ST_MISS;
          end
        end
      end
      ST_SCORED, ST_MISS: begin
        if (w_frame_tick) begin
          if (hold_cnt == c_hold_last) begin
            hold_cnt_n = '0;
            state_n    = ST_IDLE;
            ball_x_n   = c_x0;
            ball_y_n   = c_y0;
          end else begin
            hold_cnt_n = hold_cnt + HOLD_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- render
  logic signed [12:0] w_px, w_py, w_bx;
  logic               w_in_box, w_is_ball, w_is_rim, w_is_board, w_is_floor;

  assign w_px = $signed({3'b000, pixel_x});
  assign w_py = $signed({3'b000, pixel_y});
  assign w_bx = $signed({3'b000, ball_x});

  assign w_in_box = (w_px >= w_bx) && (w_px < w_bx + c_ball)
                 && (w_py >= w_y_old13) && (w_py < w_y_old13 + c_ball);

`ifdef BALL_ROUND_EN
  // Disc test in doubled coordinates so the centre lands on an integer.
  // Unsigned modular arithmetic is fine: squares of small two's-complement
  // values come out exact in 26 bits.
  logic signed [12:0] w_dx, w_dy;
  logic [25:0]        w_ex, w_ey, w_dist;

  assign w_dx      = w_px - w_bx;
  assign w_dy      = w_py - w_y_old13;
  assign w_ex      = ({{13{w_dx[12]}}, w_dx} << 1) - 26'(BALL_SIZE - 1);
  assign w_ey      = ({{13{w_dy[12]}}, w_dy} << 1) - 26'(BALL_SIZE - 1);
  assign w_dist    = w_ex * w_ex + w_ey * w_ey;
  assign w_is_ball = w_in_box && (w_dist <= 26'(BALL_SIZE * BALL_SIZE));
`else
  assign w_is_ball = w_in_box;
`endif

  assign w_is_rim   = (w_py >= c_hoop_y) && (w_py <= c_rim_bot)
                   && (w_px >= c_hoop_x) && (w_px < c_hoop_r);
  assign w_is_board = (w_px >= c_hoop_r) && (w_px <= c_bb_right)
                   && (w_py >= c_bb_top) && (w_py <= c_rim_bot);
  assign w_is_floor = (w_py >= c_floor);

  always_comb begin
    pix_color = 12'h000;
    if (!video_on)        pix_color = 12'h000;
    else if (w_is_ball)   pix_color = 12'hF80;
    else if (w_is_rim)    pix_color = 12'hF00;
    else if (w_is_board)  pix_color = 12'hFFF;
    else if (w_is_floor)  pix_color = 12'h842;
    else if (state == ST_SCORED) pix_color = 12'h0F0;
    else                  pix_color = 12'h6AF;
  end

endmodule
`default_nettype wire

// File: tb/tb_shot_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_shot_renderer                                                |
// | Purpose  : Directed self-checking bench for shot_renderer. Instance a uses |
// |            default geometry, instance b moves the hoop next to the launch  |
// |            point so a straight drop scores.                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_shot_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       p_tick = 1'b0;
  logic       video_on = 1'b0;
  logic [9:0] pixel_x = 10'd0;
  logic [9:0] pixel_y = 10'd0;
  logic       shoot = 1'b0;
  logic [3:0] vx_in = 4'd0;
  logic [5:0] vy_in = 6'd0;

  logic [11:0] rgb_a, rgb_b;
  logic        busy_a, busy_b, scored_a, scored_b;
  logic        sc_a, sc_b;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  bit          inst_q[$];
  string       tag_q[$];

  int mx, my, mvx, mvy;

  always #5 clk = ~clk;

  shot_renderer dut_a (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .shoot(shoot),
    .vx_in(vx_in), .vy_in(vy_in),
    .rgb(rgb_a), .busy(busy_a), .scored(scored_a)
  );

  shot_renderer #(.HOOP_X(36), .HOOP_Y(420)) dut_b (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .shoot(shoot),
    .vx_in(vx_in), .vy_in(vy_in),
    .rgb(rgb_b), .busy(busy_b), .scored(scored_b)
  );

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one pixel for one clock; expected colour goes into the scoreboard
  // and is compared once the registered rgb has updated.
  task automatic read_pix(input bit inst, input int px, input int py, input bit von,
                          input logic [11:0] exp, input string tag);
    logic [11:0] e;
    bit          i;
    string       t;
    @(negedge clk);
    p_tick   = 1'b1;
    video_on = von;
    pixel_x  = px[9:0];
    pixel_y  = py[9:0];
    exp_q.push_back(exp);
    inst_q.push_back(inst);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    p_tick = 1'b0;
    e = exp_q.pop_front();
    i = inst_q.pop_front();
    t = tag_q.pop_front();
    check(t, i ? rgb_b : rgb_a, e);
  endtask

  task automatic frame_tick();
    @(negedge clk);
    p_tick   = 1'b1;
    video_on = 1'b0;
    pixel_x  = 10'd0;
    pixel_y  = 10'd480;
    @(posedge clk);
    #1;
    p_tick = 1'b0;
    sc_a   = scored_a;
    sc_b   = scored_b;
  endtask

  task automatic launch(input int vx, input int vy);
    @(negedge clk);
    vx_in = vx[3:0];
    vy_in = vy[5:0];
    shoot = 1'b1;
    @(posedge clk);
    #1;
    check_bit("busy_before_launch", busy_a, 1'b0);
    @(posedge clk);
    #1;
    check_bit("busy_after_launch", busy_a, 1'b1);
    @(negedge clk);
    shoot = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    shoot = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Spec-level projectile step.
  task automatic model_step();
    mx = mx + mvx;
    my = my - mvy;
    if (mvy > -64) mvy = mvy - 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state
    repeat (5) @(posedge clk);
    #1;
    check("reset_rgb_a", rgb_a, 12'h000);
    check("reset_rgb_b", rgb_b, 12'h000);
    check_bit("reset_busy", busy_a, 1'b0);
    check_bit("reset_scored", scored_a, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- idle rendering
    read_pix(0, 100, 100, 1, 12'h6AF, "idle_sky");
    read_pix(0, 44, 404, 1, 12'hF80, "idle_ball");
    read_pix(0, 39, 404, 1, 12'h6AF, "ball_left_edge");
    read_pix(0, 48, 404, 1, 12'h6AF, "ball_right_edge");
    read_pix(0, 591, 200, 1, 12'hF00, "rim_end");
    read_pix(0, 592, 200, 1, 12'hFFF, "board_start");
    read_pix(0, 593, 160, 1, 12'hFFF, "board_top");
    read_pix(0, 593, 159, 1, 12'h6AF, "above_board");
    read_pix(0, 300, 470, 1, 12'h842, "floor_first");
    read_pix(0, 300, 469, 1, 12'h6AF, "above_floor");

    // ---------------- blanking and hold
    read_pix(0, 44, 404, 0, 12'h000, "blank_on_ball");
    read_pix(0, 44, 404, 1, 12'hF80, "ball_before_hold");
    @(negedge clk);
    pixel_x  = 10'd100;
    pixel_y  = 10'd100;
    video_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rgb_hold_no_tick", rgb_a, 12'hF80);

    // ---------------- score (instance b)
    do_reset();
    launch(0, 0);
    mx = 40; my = 400; mvx = 0; mvy = 0;
    for (int t = 1; t <= 6; t++) begin
      frame_tick();
      model_step();
      check_bit($sformatf("score_pulse_t%0d", t), sc_b, (t == 6));
      read_pix(1, mx + 4, my, 1, 12'hF80, $sformatf("score_ball_t%0d", t));
      read_pix(1, mx + 4, my - 1, 1, (t == 6) ? 12'h0F0 : 12'h6AF,
               $sformatf("score_above_t%0d", t));
    end
    check_bit("score_pulse_width", scored_b, 1'b0);
    check_bit("score_busy", busy_b, 1'b1);
    read_pix(1, 44, 415, 1, 12'hF80, "score_final_y");
    read_pix(1, 100, 100, 1, 12'h0F0, "score_sky");

    // ---------------- miss + ignored relaunch (instance a)
    do_reset();
    launch(15, 0);
    mx = 40; my = 400; mvx = 15; mvy = 0;
    for (int t = 1; t <= 12; t++) begin
      frame_tick();
      model_step();
      check_bit($sformatf("miss_no_score_t%0d", t), sc_a, 1'b0);
      check_bit($sformatf("miss_busy_t%0d", t), busy_a, 1'b1);
      read_pix(0, mx + 4, my, 1, 12'hF80, $sformatf("miss_ball_t%0d", t));
      read_pix(0, mx + 4, my - 1, 1, 12'h6AF, $sformatf("miss_above_t%0d", t));
      if (t == 3) begin
        @(negedge clk);
        vx_in = 4'd3;
        vy_in = 6'd40;
        shoot = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        shoot = 1'b0;
      end
    end
    read_pix(0, 224, 466, 1, 12'hF80, "miss_pos_220_466");
    for (int t = 13; t <= 72; t++) begin
      frame_tick();
      check_bit($sformatf("hold_no_score_t%0d", t), sc_a, 1'b0);
      if (t == 13) read_pix(0, 224, 466, 1, 12'hF80, "miss_frozen");
      if (t == 71) check_bit("hold_busy_t71", busy_a, 1'b1);
      if (t == 72) check_bit("hold_idle_t72", busy_a, 1'b0);
    end
    read_pix(0, 44, 404, 1, 12'hF80, "miss_snap_back");
    read_pix(0, 224, 466, 1, 12'h6AF, "miss_old_pos_clear");

    // ---------------- reset mid-flight
    do_reset();
    launch(15, 0);
    for (int t = 1; t <= 3; t++) frame_tick();
    read_pix(0, 89, 403, 1, 12'hF80, "midflight_ball");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_bit("abort_busy", busy_a, 1'b0);
    check("abort_rgb", rgb_a, 12'h000);
    @(negedge clk);
    reset = 1'b1;
    read_pix(0, 44, 404, 1, 12'hF80, "abort_ball_home");
    read_pix(0, 89, 403, 1, 12'h6AF, "abort_old_pos_clear");
    check_bit("abort_busy_after", busy_a, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
